// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared width, opcode and field-position definitions for the processor
package processor_pkg;

   localparam int BITNESS = 8;

   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int IMM_LSB = 0;
   localparam int PIN_LSB = 0;
   localparam int VAL_BIT = 3;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_MOV  = 4'h2,
      OP_ADD  = 4'h3,
      OP_SUB  = 4'h4,
      OP_AND  = 4'h5,
      OP_OR   = 4'h6,
      OP_XOR  = 4'h7,
      OP_NOT  = 4'h8,
      OP_IN   = 4'h9,
      OP_OUT  = 4'hA,
      OP_PSET = 4'hB,
      OP_JMP  = 4'hC,
      OP_JZ   = 4'hD,
      OP_JNZ  = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

endpackage

// File: rtl/processor_alu.sv
// rtl/processor_alu.sv - combinational ALU; non-arithmetic opcodes pass operand b through
module processor_alu
   import processor_pkg::*;
(
   input  logic [BITNESS-1:0] a,
   input  logic [BITNESS-1:0] b,
   input  opcode_e            op,
   output logic [BITNESS-1:0] result,
   output logic               carry,
   output logic               zero
);

   logic [BITNESS:0] sum;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      result = b;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[BITNESS-1:0];
            carry  = sum[BITNESS];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         default: result = b;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/processor.sv
// rtl/processor.sv - single-cycle processor: register file, flags, pc and pin logic
module processor
   import processor_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic [BITNESS-1:0] pc,
   input  logic [15:0]        ins,
   input  logic               pin_in  [BITNESS],
   output logic               pin_out [BITNESS]
);

   // Declaration values match the reset values so outputs are defined before the first reset edge.
   logic [BITNESS-1:0]      pc_q     = '0;
   logic [3:0][BITNESS-1:0] regs_q   = '0;
   logic [BITNESS-1:0]      pins_q   = '0;
   logic                    z_q      = 1'b0;
   logic                    c_q      = 1'b0;
   logic                    halted_q = 1'b0;

   opcode_e            op;
   logic [1:0]         rd;
   logic [1:0]         rs;
   logic [7:0]         imm;
   logic [2:0]         pin_idx;
   logic               pin_val;
   logic [BITNESS-1:0] rd_val;
   logic [BITNESS-1:0] rs_val;
   logic [BITNESS-1:0] pin_vec;
   logic [BITNESS-1:0] alu_b;
   logic [BITNESS-1:0] alu_result;
   logic               alu_carry;
   logic               alu_zero;
   logic [BITNESS-1:0] pc_inc;

   assign op      = opcode_e'(ins[OP_LSB +: 4]);
   assign rd      = ins[RD_LSB +: 2];
   assign rs      = ins[RS_LSB +: 2];
   assign imm     = ins[IMM_LSB +: 8];
   assign pin_idx = ins[PIN_LSB +: 3];
   assign pin_val = ins[VAL_BIT];
   assign rd_val  = regs_q[rd];
   assign rs_val  = regs_q[rs];
   assign pc_inc  = pc_q + BITNESS'(1);
   assign pc      = pc_q;

   for (genvar i = 0; i < BITNESS; i++) begin : g_pins
      assign pin_vec[i] = pin_in[i];
      assign pin_out[i] = pins_q[i];
   end

   // LDI and IN route their source through the ALU pass-through so Z comes for free.
   assign alu_b = (op == OP_LDI) ? BITNESS'(imm) :
                  (op == OP_IN)  ? pin_vec       : rs_val;

   processor_alu u_alu (
      .a      (rd_val),
      .b      (alu_b),
      .op     (op),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= '0;
         regs_q   <= '0;
         pins_q   <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         halted_q <= 1'b0;
      end else if (!halted_q) begin
         pc_q <= pc_inc;
         case (op)
            OP_LDI, OP_MOV: regs_q[rd] <= alu_result;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
               regs_q[rd] <= alu_result;
               z_q        <= alu_zero;
               c_q        <= alu_carry;
            end
            OP_IN: begin
               regs_q[rd] <= alu_result;
               z_q        <= alu_zero;
            end
            OP_OUT:  pins_q          <= rs_val;
            OP_PSET: pins_q[pin_idx] <= pin_val;
            OP_JMP:  pc_q            <= BITNESS'(imm);
            OP_JZ:   if (z_q)  pc_q  <= BITNESS'(imm);
            OP_JNZ:  if (!z_q) pc_q  <= BITNESS'(imm);
            OP_HALT: begin
               halted_q <= 1'b1;
               pc_q     <= pc_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - scoreboard bench for the processor
module tb_processor;
   import processor_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [BITNESS-1:0] pc;
   logic [15:0]        ins;
   logic               pin_in  [BITNESS];
   logic               pin_out [BITNESS];
   logic [15:0]        imem    [256];
   logic [BITNESS-1:0] pins_obs;

   typedef struct {
      string      name;
      logic [7:0] drive;
      logic [7:0] pc;
      logic [7:0] pins;
   } exp_t;

   exp_t sb [$];
   exp_t e;
   int   n_run  = 0;
   int   n_fail = 0;

   processor dut (
      .clk     (clk),
      .rst     (rst),
      .pc      (pc),
      .ins     (ins),
      .pin_in  (pin_in),
      .pin_out (pin_out)
   );

   always #5 clk = ~clk;
   always_comb ins = imem[pc];
   always_comb for (int i = 0; i < BITNESS; i++) pins_obs[i] = pin_out[i];

   function automatic logic [15:0] enc(opcode_e op, int rd, int rs, int imm);
      return {op, 2'(rd), 2'(rs), 8'(imm)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pins(logic [7:0] v);
      for (int i = 0; i < BITNESS; i++) pin_in[i] = v[i];
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = enc(OP_NOP, 0, 0, 0);
   endtask

   task automatic push(string n, logic [7:0] d, logic [7:0] p, logic [7:0] q);
      sb.push_back('{n, d, p, q});
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      drive_pins(8'h00);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      n_run++; if (pc !== 8'h00) begin n_fail++; $display("FAIL t0_pc: got %h want 00", pc); end
      n_run++; if (pins_obs !== 8'h00) begin n_fail++; $display("FAIL t0_pins: got %h want 00", pins_obs); end
      clear_imem();
      imem[0] = enc(OP_LDI, 0, 0, 8'h77);
      reset_dut();
      n_run++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h want 00", pc); end
      n_run++; if (pins_obs !== 8'h00) begin n_fail++; $display("FAIL rst_pins: got %h want 00", pins_obs); end
      for (int r = 0; r < 4; r++) begin
         n_run++;
         if (dut.regs_q[r] !== 8'h00) begin n_fail++; $display("FAIL rst_r%0d: got %h want 00", r, dut.regs_q[r]); end
      end
      n_run++;
      if ({dut.z_q, dut.c_q, dut.halted_q} !== 3'b000) begin
         n_fail++; $display("FAIL rst_flags: got %b want 000", {dut.z_q, dut.c_q, dut.halted_q});
      end
   endtask

   task automatic test_pset();
      clear_imem();
      imem[0] = enc(OP_PSET, 0, 0, 8'h08);
      imem[1] = enc(OP_PSET, 0, 0, 8'h09);
      imem[2] = enc(OP_PSET, 0, 0, 8'h0F);
      imem[3] = enc(OP_PSET, 0, 0, 8'h00);
      push("pset_p0", 8'h00, 8'h01, 8'h01);
      push("pset_p1", 8'h00, 8'h02, 8'h03);
      push("pset_p7", 8'h00, 8'h03, 8'h83);
      push("pset_clr", 8'h00, 8'h04, 8'h82);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
   endtask

   task automatic test_branch();
      clear_imem();
      imem[0] = enc(OP_LDI, 0, 0, 8'h05);
      imem[1] = enc(OP_LDI, 1, 0, 8'h05);
      imem[2] = enc(OP_SUB, 0, 1, 0);
      imem[3] = enc(OP_JZ, 0, 0, 8'h08);
      push("jz_e1", 8'h00, 8'h01, 8'h00);
      push("jz_e2", 8'h00, 8'h02, 8'h00);
      push("jz_e3", 8'h00, 8'h03, 8'h00);
      push("jz_taken", 8'h00, 8'h08, 8'h00);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
      n_run++; if (dut.z_q !== 1'b1) begin n_fail++; $display("FAIL jz_z: got %b want 1", dut.z_q); end

      imem[1] = enc(OP_LDI, 1, 0, 8'h04);
      imem[4] = enc(OP_JNZ, 0, 0, 8'h10);
      push("jz_e1b", 8'h00, 8'h01, 8'h00);
      push("jz_e2b", 8'h00, 8'h02, 8'h00);
      push("jz_e3b", 8'h00, 8'h03, 8'h00);
      push("jz_not_taken", 8'h00, 8'h04, 8'h00);
      push("jnz_taken", 8'h00, 8'h10, 8'h00);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
      n_run++; if ({dut.z_q, dut.c_q} !== 2'b00) begin n_fail++; $display("FAIL sub_flags: got %b want 00", {dut.z_q, dut.c_q}); end
      n_run++; if (dut.regs_q[0] !== 8'h01) begin n_fail++; $display("FAIL sub_r0: got %h want 01", dut.regs_q[0]); end
   endtask

   task automatic test_add_carry();
      clear_imem();
      imem[0] = enc(OP_LDI, 3, 0, 8'hA5);
      imem[1] = enc(OP_OUT, 0, 3, 0);
      imem[2] = enc(OP_LDI, 0, 0, 8'hFF);
      imem[3] = enc(OP_LDI, 1, 0, 8'h01);
      imem[4] = enc(OP_ADD, 0, 1, 0);
      imem[5] = enc(OP_LDI, 2, 0, 8'h12);
      imem[6] = enc(OP_OUT, 0, 0, 0);
      push("add_e1", 8'h00, 8'h01, 8'h00);
      push("add_out_a5", 8'h00, 8'h02, 8'hA5);
      push("add_e3", 8'h00, 8'h03, 8'hA5);
      push("add_e4", 8'h00, 8'h04, 8'hA5);
      push("add_e5", 8'h00, 8'h05, 8'hA5);
      push("add_e6", 8'h00, 8'h06, 8'hA5);
      push("add_out_0", 8'h00, 8'h07, 8'h00);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
      n_run++; if (dut.regs_q[0] !== 8'h00) begin n_fail++; $display("FAIL add_r0: got %h want 00", dut.regs_q[0]); end
      n_run++; if (dut.regs_q[2] !== 8'h12) begin n_fail++; $display("FAIL ldi_r2: got %h want 12", dut.regs_q[2]); end
      n_run++; if ({dut.z_q, dut.c_q} !== 2'b11) begin n_fail++; $display("FAIL add_flags: got %b want 11", {dut.z_q, dut.c_q}); end
   endtask

   task automatic test_logic();
      clear_imem();
      imem[0]  = enc(OP_LDI, 0, 0, 8'hF0);
      imem[1]  = enc(OP_LDI, 1, 0, 8'h3C);
      imem[2]  = enc(OP_AND, 0, 1, 0);
      imem[3]  = enc(OP_OUT, 0, 0, 0);
      imem[4]  = enc(OP_OR, 0, 1, 0);
      imem[5]  = enc(OP_OUT, 0, 0, 0);
      imem[6]  = enc(OP_XOR, 0, 0, 0);
      imem[7]  = enc(OP_NOT, 0, 0, 0);
      imem[8]  = enc(OP_OUT, 0, 0, 0);
      imem[9]  = enc(OP_LDI, 2, 0, 8'h01);
      imem[10] = enc(OP_SUB, 2, 0, 0);
      imem[11] = enc(OP_OUT, 0, 2, 0);
      push("log_e1", 8'h00, 8'h01, 8'h00);
      push("log_e2", 8'h00, 8'h02, 8'h00);
      push("log_e3", 8'h00, 8'h03, 8'h00);
      push("and_out", 8'h00, 8'h04, 8'h30);
      push("log_e5", 8'h00, 8'h05, 8'h30);
      push("or_out", 8'h00, 8'h06, 8'h3C);
      push("log_e7", 8'h00, 8'h07, 8'h3C);
      push("log_e8", 8'h00, 8'h08, 8'h3C);
      push("xor_not_out", 8'h00, 8'h09, 8'hFF);
      push("log_e10", 8'h00, 8'h0A, 8'hFF);
      push("log_e11", 8'h00, 8'h0B, 8'hFF);
      push("sub_borrow_out", 8'h00, 8'h0C, 8'h02);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
      n_run++; if ({dut.z_q, dut.c_q} !== 2'b01) begin n_fail++; $display("FAIL borrow_flags: got %b want 01", {dut.z_q, dut.c_q}); end
   endtask

   task automatic test_in();
      clear_imem();
      imem[0] = enc(OP_IN, 2, 0, 0);
      imem[1] = enc(OP_OUT, 0, 2, 0);
      imem[2] = enc(OP_IN, 3, 0, 0);
      imem[3] = enc(OP_OUT, 0, 3, 0);
      imem[4] = enc(OP_IN, 1, 0, 0);
      push("in_p0", 8'h01, 8'h01, 8'h00);
      push("out_p0", 8'h55, 8'h02, 8'h01);
      push("in_p7", 8'h80, 8'h03, 8'h01);
      push("out_p7", 8'h00, 8'h04, 8'h80);
      push("in_zero", 8'h00, 8'h05, 8'h80);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
      n_run++; if (dut.z_q !== 1'b1) begin n_fail++; $display("FAIL in_z: got %b want 1", dut.z_q); end
      n_run++; if (dut.regs_q[2] !== 8'h01) begin n_fail++; $display("FAIL in_r2: got %h want 01", dut.regs_q[2]); end
   endtask

   task automatic test_halt();
      clear_imem();
      imem[0] = enc(OP_PSET, 0, 0, 8'h08);
      imem[1] = enc(OP_PSET, 0, 0, 8'h0A);
      imem[3] = enc(OP_HALT, 0, 0, 0);
      imem[4] = enc(OP_PSET, 0, 0, 8'h0D);
      push("halt_e1", 8'h00, 8'h01, 8'h01);
      push("halt_e2", 8'h00, 8'h02, 8'h05);
      push("halt_e3", 8'h00, 8'h03, 8'h05);
      push("halt_retire", 8'h00, 8'h03, 8'h05);
      for (int i = 0; i < 10; i++) push("halt_hold", 8'hFF, 8'h03, 8'h05);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
      push("halt_rst", 8'h00, 8'h00, 8'h00);
      push("halt_resume", 8'h00, 8'h01, 8'h01);
      rst = 1'b1;
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick(); rst = 1'b0;
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
   endtask

   task automatic test_wrap();
      clear_imem();
      imem[0] = enc(OP_JMP, 0, 0, 8'hFF);
      push("jmp_ff", 8'h00, 8'hFF, 8'h00);
      push("wrap_00", 8'h00, 8'h00, 8'h00);
      push("jmp_again", 8'h00, 8'hFF, 8'h00);
      reset_dut();
      while (sb.size() != 0) begin
         e = sb.pop_front(); drive_pins(e.drive); tick();
         n_run++; if (pc !== e.pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc); end
         n_run++; if (pins_obs !== e.pins) begin n_fail++; $display("FAIL %s pins: got %h want %h", e.name, pins_obs, e.pins); end
      end
   endtask

   initial begin
      drive_pins(8'h00);
      clear_imem();
      #1;
      test_reset();
      test_pset();
      test_branch();
      test_add_carry();
      test_logic();
      test_in();
      test_halt();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter BITNESS, default 8; data word, PC and pin-vector width; defined in shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc  output  BITNESS  address of current instruction; registered.
REQ-005 ins  input  16  instruction at pc; combinational from external memory, valid same cycle.
REQ-006 pin_in  input  BITNESS x 1-bit unpacked array  general-purpose input pins.
REQ-007 pin_out  output  BITNESS x 1-bit unpacked array  general-purpose output pins; registered.

Function
REQ-008 Single-cycle, non-pipelined; each rising edge without rst retires exactly the instruction on ins.
REQ-009 State: four BITNESS-bit registers r0-r3, flag Z, flag C, halted bit, pc, pin_out.
REQ-010 Fields: op=ins[15:12], rd=ins[11:10], rs=ins[9:8], imm=ins[7:0], p=ins[2:0] (pin index), v=ins[3].
REQ-011 Unless stated otherwise, pc <= pc+1 modulo 2^BITNESS; 0xFF wraps to 0x00.
REQ-012 0x0 NOP: no state change except pc.
REQ-013 0x1 LDI: rd <= imm; flags unchanged.
REQ-014 0x2 MOV: rd <= rs; flags unchanged.
REQ-015 0x3 ADD: rd <= rd+rs mod 256; C <= carry-out; Z <= (result==0).
REQ-016 0x4 SUB: rd <= rd-rs mod 256; C <= borrow (rd<rs); Z <= (result==0).
REQ-017 0x5 AND, 0x6 OR, 0x7 XOR: rd <= rd op rs; Z updated; C <= 0.
REQ-018 0x8 NOT: rd <= ~rd; Z updated; C <= 0.
REQ-019 0x9 IN: rd <= packed pin_in (bit i = pin_in[i]); Z updated.
REQ-020 0xA OUT: pin_out[i] <= rs[i] for every i.
REQ-021 0xB PSET: pin_out[p] <= v; other pins unchanged.
REQ-022 0xC JMP: pc <= imm.
REQ-023 0xD JZ: pc <= imm if Z=1 else pc+1; 0xE JNZ: pc <= imm if Z=0 else pc+1.
REQ-024 0xF HALT: halted <= 1; pc holds; while halted, all state frozen until rst.
REQ-025 Same-register operands (rd==rs) legal; operands read before write.
REQ-026 pin_in sampled only on IN edge; no synchronizer inside block.

Reset
REQ-027 On rising edge with rst=1: pc=0, r0-r3=0, Z=0, C=0, halted=0, all pin_out=0; instruction on ins discarded.
REQ-028 rst overrides any instruction, including HALT, at any cycle mid-program.
REQ-029 All state registers SHALL carry the same values as time-zero initial values, so outputs are defined before the first clocked reset.

Structure
REQ-030 Shared package: BITNESS, opcode enumeration (16 values), field bit positions.
REQ-031 One sub-module alu: combinational; inputs a, b, op; outputs result, carry, zero.
REQ-032 Register file, flags, pc and pin logic in processor top; no memories inside block.

Verification
REQ-033 Reset then program PSET p=0 v=1; PSET p=1 v=1 -> after edge 1 pin_out[0]=1; after edge 2 pin_out[1]=1, pc=2.
REQ-034 LDI r0,0x05; LDI r1,0x05; SUB r0,r1; JZ 0x08 -> Z=1, pc=0x08 after edge 4; same with r1=0x04 -> pc=4.
REQ-035 LDI r0,0xFF; LDI r1,0x01; ADD r0,r1; OUT r0 -> r0=0, C=1, Z=1, all pin_out=0.
REQ-036 pin_in[0]=1, others 0; IN r2; OUT r2 -> pin_out[0]=1, pin_out[1..7]=0.
REQ-037 HALT at pc=3 -> pc stays 3 over 10 edges, pins frozen; assert rst one edge -> pc=0, pins 0.
REQ-038 JMP 0xFF then NOP at 0xFF -> pc wraps to 0x00.
